// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming conditional top-2 argmax.
// Candidate fields are sized to package ceilings so one struct serves every parameterisation.
package argmax_pkg;

    localparam int IDX_MAX = 16;
    localparam int VAL_MAX = 32;
    localparam logic [IDX_MAX:0] IDX_NONE = '1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    typedef struct packed {
        logic               vld;
        logic [IDX_MAX-1:0] idx;
        logic [VAL_MAX-1:0] val;
    } cand_t;

    localparam cand_t CAND_EMPTY = '{vld: 1'b0, idx: '0, val: '0};

    function automatic int idx_w(input int size);
        return $clog2(size);
    endfunction

    // An empty slot is beaten by anything; ties go to the later entry only when tie_later is set.
    function automatic logic cand_beats(input cand_t c, input cand_t r, input logic tie_later);
        if (!r.vld) begin
            return 1'b1;
        end
        if (tie_later) begin
            return c.val >= r.val;
        end
        return c.val > r.val;
    endfunction

endpackage

// File: rtl/top2_insert.sv
// One link of the insertion chain: folds a single candidate into a running top-2.
// An ineligible candidate arrives with vld low and passes the pair through unchanged.
module top2_insert
    import argmax_pkg::*;
#(
    parameter logic TIE_LATER = 1'b1
) (
    input  cand_t i_first,
    input  cand_t i_second,
    input  cand_t i_cand,
    output cand_t o_first,
    output cand_t o_second
);

    always_comb begin
        o_first  = i_first;
        o_second = i_second;
        if (i_cand.vld && cand_beats(i_cand, i_first, TIE_LATER)) begin
            o_second = i_first;
            o_first  = i_cand;
        end else if (i_cand.vld && cand_beats(i_cand, i_second, TIE_LATER)) begin
            o_second = i_cand;
        end
    end

endmodule

// File: rtl/cond_top2_argmax_stream.sv
// Frame-based top-2 argmax over SIZE entries delivered LANES per beat, with a held result
// that waits for the consumer before the next frame is accepted.
module cond_top2_argmax_stream
    import argmax_pkg::*;
#(
    parameter int   SIZE      = 16,
    parameter int   LANES     = 4,
    parameter int   VAL_WIDTH = 8,
    parameter logic TIE_LATER = 1'b1,
    localparam int  IDX_W     = (idx_w(SIZE) < 1) ? 1 : idx_w(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           in_cond,
    input  logic [LANES*VAL_WIDTH-1:0] in_val,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W:0]             first_idx,
    output logic [IDX_W:0]             second_idx,
    output logic [VAL_WIDTH-1:0]       first_val,
    output logic [VAL_WIDTH-1:0]       second_val,
    output logic                       first_vld,
    output logic                       second_vld
);

    localparam int BEATS  = SIZE / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [BEAT_W-1:0]   r_beat;
    cand_t               r_work_first;
    cand_t               r_work_second;
    logic                r_first_vld;
    logic                r_second_vld;
    logic [IDX_W-1:0]    r_first_idx;
    logic [IDX_W-1:0]    r_second_idx;
    logic [VAL_WIDTH-1:0] r_first_val;
    logic [VAL_WIDTH-1:0] r_second_val;

    logic  w_accept;
    logic  w_last;
    cand_t w_seed_first;
    cand_t w_seed_second;
    cand_t w_merged_first;
    cand_t w_merged_second;

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_beat == BEAT_W'(BEATS - 1));

    // Beat 0 always starts from an empty pair so nothing survives from the previous frame.
    assign w_seed_first  = (r_beat == '0) ? CAND_EMPTY : r_work_first;
    assign w_seed_second = (r_beat == '0) ? CAND_EMPTY : r_work_second;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            cand_t            w_f_in;
            cand_t            w_s_in;
            cand_t            w_cand;
            cand_t            w_f_out;
            cand_t            w_s_out;
            logic [IDX_W-1:0] w_idx;

            assign w_idx      = IDX_W'(int'(r_beat) * LANES + gi);
            assign w_cand.vld = in_cond[gi];
            assign w_cand.idx = IDX_MAX'(w_idx);
            assign w_cand.val = VAL_MAX'(in_val[gi*VAL_WIDTH +: VAL_WIDTH]);

            if (gi == 0) begin : g_head
                assign w_f_in = w_seed_first;
                assign w_s_in = w_seed_second;
            end else begin : g_link
                assign w_f_in = g_lane[gi-1].w_f_out;
                assign w_s_in = g_lane[gi-1].w_s_out;
            end

            top2_insert #(
                .TIE_LATER (TIE_LATER)
            ) u_insert (
                .i_first  (w_f_in),
                .i_second (w_s_in),
                .i_cand   (w_cand),
                .o_first  (w_f_out),
                .o_second (w_s_out)
            );
        end
    endgenerate

    assign w_merged_first  = g_lane[LANES-1].w_f_out;
    assign w_merged_second = g_lane[LANES-1].w_s_out;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_ACCUM: if (!clear && w_accept && w_last) w_state_next = ST_DONE;
            ST_DONE:  if (clear || out_ready)          w_state_next = ST_ACCUM;
            default:  w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear wins over a same-cycle beat; the output registers keep their data across clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat        <= '0;
            r_work_first  <= CAND_EMPTY;
            r_work_second <= CAND_EMPTY;
            r_first_vld   <= 1'b0;
            r_second_vld  <= 1'b0;
            r_first_idx   <= '0;
            r_second_idx  <= '0;
            r_first_val   <= '0;
            r_second_val  <= '0;
        end else if (clear) begin
            r_beat        <= '0;
            r_work_first  <= CAND_EMPTY;
            r_work_second <= CAND_EMPTY;
        end else if (w_accept) begin
            r_work_first  <= w_merged_first;
            r_work_second <= w_merged_second;
            if (w_last) begin
                r_beat       <= '0;
                r_first_vld  <= w_merged_first.vld;
                r_second_vld <= w_merged_second.vld;
                r_first_idx  <= w_merged_first.idx[IDX_W-1:0];
                r_second_idx <= w_merged_second.idx[IDX_W-1:0];
                r_first_val  <= w_merged_first.val[VAL_WIDTH-1:0];
                r_second_val <= w_merged_second.val[VAL_WIDTH-1:0];
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    assign first_vld  = r_first_vld;
    assign second_vld = r_second_vld;
    assign first_idx  = r_first_vld  ? {1'b0, r_first_idx}  : IDX_NONE[IDX_W:0];
    assign second_idx = r_second_vld ? {1'b0, r_second_idx} : IDX_NONE[IDX_W:0];
    assign first_val  = r_first_vld  ? r_first_val  : '0;
    assign second_val = r_second_vld ? r_second_val : '0;

endmodule

// File: doc/cond_top2_argmax_stream.md
# cond_top2_argmax_stream

Streaming conditional top-2 argmax. Accepts a frame of SIZE values as SIZE/LANES beats of LANES lanes over a valid/ready handshake. Among the entries whose condition bit is set, it reports the index and value of the largest and second-largest entry. It sits between the score-generation stage and the selection/dispatch logic, and replaces the single-cycle combinational argmax with a frame-based, back-pressured, parametrised unit.

## Interface
- SIZE, 16: entries per frame; must be a multiple of LANES.
- LANES, 4: entries accepted per beat; 1 ≤ LANES ≤ SIZE.
- VAL_WIDTH, 8: unsigned value width.
- TIE_LATER, 1: 1 = on equal values the higher index wins (≥ compare); 0 = the lower index wins (> compare).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous frame abort; discards the partial frame and returns to ACCUM.
- in_valid  in  1  a beat is present.
- in_ready  out  1  the block can accept a beat.
- in_cond  in  LANES  per-lane eligibility.
- in_val  in  LANES×VAL_WIDTH  per-lane value; lane k of beat b is entry b·LANES+k.
- out_valid  out  1  the result is held.
- out_ready  in  1  the consumer takes the result.
- first_idx, second_idx  out  IDX_W+1  winning indices, where IDX_W=$clog2(SIZE); all-ones (−1) means none.
- first_val, second_val  out  VAL_WIDTH  winning values; 0 when the matching *_vld is low.
- first_vld, second_vld  out  1  the matching winner exists.

## Operation
- States: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
- Beat counter `beat` runs 0..SIZE/LANES−1; a beat is accepted when in_valid && in_ready.
- Candidate insertion, applied per lane in ascending lane order, as a combinational chain inside one beat:
  - "c beats r" means: r is invalid, or c.val ≥ r.val when TIE_LATER=1, or c.val > r.val when TIE_LATER=0.
  - If cond=1 and c beats first: second←first, first←c.
  - Else if cond=1 and c beats second: second←c.
  - Else no change.
- Beat 0 starts from an empty top-2 (both invalid), not from the registered state, so frames never leak into one another.
- On the final beat (beat=SIZE/LANES−1):
  - Register the merged result into the output registers.
  - Go to DONE; beat←0.
- DONE: outputs hold stable until out_ready=1; then go to ACCUM the next cycle. Outputs stay valid data but out_valid drops.
- Widths: indices are computed at IDX_W bits and zero-extended to IDX_W+1. The −1 sentinel appears only when *_vld=0.
- clear in ACCUM: beat←0 and the working registers are invalidated. clear in DONE: the result is dropped and the state goes to ACCUM. clear overrides a simultaneous beat acceptance or out_ready.

## Timing
- Reset values:
  - state=ACCUM, beat=0, in_ready=1, out_valid=0.
  - first_vld=second_vld=0.
  - first_idx=second_idx=all-ones.
  - first_val=second_val=0.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Throughput: one frame per SIZE/LANES+1 cycles with out_ready tied high (one DONE cycle acts as a bubble).
- in_ready is a registered function of state only. It never depends combinationally on in_valid or out_ready.
- out_* remain stable while out_valid && !out_ready.
- rst mid-frame or in DONE returns to reset values immediately (asynchronous).
- SIZE=LANES: every beat is both first and final; out_valid follows every accepted beat.

## Structure
- Package argmax_pkg:
  - function idx_w(size) returning $clog2(size).
  - typedef struct cand_t {logic vld; logic [IDX_MAX-1:0] idx; logic [VAL_MAX-1:0] val;} with package-level width ceilings.
  - localparam IDX_NONE.
- Sub-module top2_insert: combinational; inputs first, second, candidate cand_t and TIE_LATER; outputs the updated first and second. It is instantiated LANES times in a chain.
- The top level holds the FSM, the beat counter, the working registers and the output registers.

## Test plan
- SIZE=8, LANES=4, VAL_WIDTH=4, TIE_LATER=1, vals [3,7,2,7,5,1,7,0], cond all 1 → first_idx=6 val 7, second_idx=3 val 7, both vld, out_valid 1 cycle after beat 1.
- Same stimulus, TIE_LATER=0 → first_idx=1 val 7, second_idx=3 val 7.
- cond=8'b0000_0100, vals as above → first_idx=2 val 2 vld=1; second_idx=4'b1111, second_vld=0, second_val=0. cond=0 → both invalid, indices 4'b1111.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and outputs stable throughout; on out_ready=1 the next frame is accepted the following cycle; frame 2 results are unaffected by frame 1.
- Assert clear after beat 0 of a frame containing val 15 at index 0, then send a full frame with max 9 at index 5 → first_idx=5, index 0 is not reported.
- Assert rst between beat 0 and beat 1 → all outputs at reset values the same cycle; the next complete frame produces correct results.
